// File: rtl/sig_delay_ctrl.sv
// Circular-buffer controller for the dual-port sample RAM: writes every strobed
// sample and reads back the one written D strobes earlier once history allows.
module sig_delay_ctrl #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] offset,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  filled
);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic [ADDR_WIDTH-1:0] delay;
    logic                  grant;

    // Zero offset would alias the write address, so it is treated as one.
    always_comb begin
        delay = (offset == '0) ? ADDR_WIDTH'(1) : offset;
        grant = (fill_cnt >= delay);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_en;
            wr_en     <= en;
            rd_en     <= en & grant;
            if (en) begin
                wr_addr <= wr_ptr;
                wr_data <= sample_in;
                wr_ptr  <= wr_ptr + ADDR_WIDTH'(1);
                if (fill_cnt != '1) begin
                    fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
                end
                if (grant) begin
                    rd_addr <= wr_ptr - delay;
                    state   <= RUN;
                end else begin
                    state   <= FILL;
                end
            end
        end
    end

    assign filled   = (state == RUN);
    assign out_data = ram_dout;

endmodule
